// File: rtl/spram_be_init.sv
// ---------------------------------------------------------------------------
// spram_be_init
//   Single-port RAM with per-byte write enables and a self-clearing init
//   sweep. After reset, the RAM is zeroed one word per cycle. busy stays high
//   during the sweep, and all accesses made in that time are dropped.
//   Reads (and writes too, when WRITE_FIRST=1) return data on out with a
//   one-cycle out_valid pulse, 1+OUT_REG cycles after the access is accepted.
//
// Ports
//   clk        in   1     single clock, rising edge
//   reset      in   1     asynchronous active-high reset
//   en         in   1     access request
//   address    in   AW    word address
//   wren       in   1     1 = write, 0 = read
//   byteena    in   DW/8  per-byte write enable
//   data       in   DW    write data
//   out        out  DW    registered read data (holds between pulses)
//   out_valid  out  1     pulse: new data on out
//   busy       out  1     init sweep running
// ---------------------------------------------------------------------------
module spram_be_init #(
    parameter int AW          = 10,
    parameter int DEPTH       = 1024,
    parameter int DW          = 32,
    parameter int OUT_REG     = 0,
    parameter int WRITE_FIRST = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [AW-1:0]   address,
    input  logic            wren,
    input  logic [DW/8-1:0] byteena,
    input  logic [DW-1:0]   data,
    output logic [DW-1:0]   out,
    output logic            out_valid,
    output logic            busy
);

    localparam int            NB        = DW / 8;
    localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic {INIT, READY} state_t;

    state_t        r_state, w_state_nxt;
    logic [AW-1:0] r_init_cnt, w_init_cnt_nxt;

    logic          w_acc, w_acc_rd, w_acc_wr, w_in_range, w_qual;
    logic [DW-1:0] w_rd_word, w_merged, w_p1_data;

    logic [DW-1:0] r_mem [DEPTH];

    logic          r_vld_p1;
    logic [DW-1:0] r_out_p1;

    // Replace the bytes of old_w that have be[i] set with the matching bytes of new_w.
    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_w,
                                                  input logic [DW-1:0] new_w,
                                                  input logic [NB-1:0] be);
        logic [DW-1:0] res;
        res = old_w;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

    // Init FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= INIT;
            r_init_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_cnt <= w_init_cnt_nxt;
        end
    end

    // Init FSM: next state. The sweep leaves INIT on the edge that writes the last word.
    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        busy           = 1'b0;
        case (r_state)
            INIT: begin
                busy           = 1'b1;
                w_init_cnt_nxt = r_init_cnt + AW'(1);
                if (r_init_cnt == LAST_ADDR) w_state_nxt = READY;
            end
            READY:   busy = 1'b0;
            default: w_state_nxt = INIT;
        endcase
    end

    // Access qualification
    assign w_in_range = ({1'b0, address} < DEPTH_W);
    assign w_acc      = en && (r_state == READY);
    assign w_acc_rd   = w_acc && !wren;
    assign w_acc_wr   = w_acc && wren;
    assign w_qual     = w_acc_rd || (w_acc_wr && (WRITE_FIRST != 0));

    // Out-of-range reads return zero, and out-of-range writes are not merged.
    assign w_rd_word  = w_in_range ? r_mem[address] : '0;
    assign w_merged   = w_in_range ? merge_bytes(w_rd_word, data, byteena) : '0;
    assign w_p1_data  = wren ? w_merged : w_rd_word;

    // Storage: no reset, because the sweep clears the contents.
    always_ff @(posedge clk) begin
        if (r_state == INIT) begin
            r_mem[r_init_cnt] <= '0;
        end else if (w_acc_wr && w_in_range) begin
            r_mem[address] <= w_merged;
        end
    end

    // ---- stage p1: array output register ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld_p1 <= 1'b0;
            r_out_p1 <= '0;
        end else begin
            r_vld_p1 <= w_qual;
            if (w_qual) r_out_p1 <= w_p1_data;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic          r_vld_p2;
            logic [DW-1:0] r_out_p2;

            // ---- stage p2: optional extra output register ----
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_vld_p2 <= 1'b0;
                    r_out_p2 <= '0;
                end else begin
                    r_vld_p2 <= r_vld_p1;
                    if (r_vld_p1) r_out_p2 <= r_out_p1;
                end
            end

            assign out       = r_out_p2;
            assign out_valid = r_vld_p2;
        end else begin : g_no_out_reg
            assign out       = r_out_p1;
            assign out_valid = r_vld_p1;
        end
    endgenerate

endmodule

// File: tb/tb_spram_be_init.sv
// ---------------------------------------------------------------------------
// tb_spram_be_init
//   Two instances share one stimulus stream:
//     u_dut0: AW=10 DEPTH=1024 OUT_REG=0 WRITE_FIRST=0
//     u_dut1: AW=10 DEPTH=1000 OUT_REG=1 WRITE_FIRST=1
//   Inputs change 1 ns after a rising edge, and outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_spram_be_init;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [9:0]  address;
    logic        wren;
    logic [3:0]  byteena;
    logic [31:0] data;

    logic [31:0] out0, out1;
    logic        vld0, vld1, busy0, busy1;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spram_be_init #(.AW(10), .DEPTH(1024), .DW(32), .OUT_REG(0), .WRITE_FIRST(0)) u_dut0 (
        .clk(clk), .reset(reset), .en(en), .address(address), .wren(wren),
        .byteena(byteena), .data(data), .out(out0), .out_valid(vld0), .busy(busy0)
    );

    spram_be_init #(.AW(10), .DEPTH(1000), .DW(32), .OUT_REG(1), .WRITE_FIRST(1)) u_dut1 (
        .clk(clk), .reset(reset), .en(en), .address(address), .wren(wren),
        .byteena(byteena), .data(data), .out(out1), .out_valid(vld1), .busy(busy1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic access(input logic we, input logic [9:0] a, input logic [3:0] be,
                          input logic [31:0] d);
        en = 1'b1; wren = we; address = a; byteena = be; data = d;
        tick();
        en = 1'b0; wren = 1'b0;
    endtask

    // Run from reset release through the sweep and record when each busy falls.
    task automatic init_sweep(input string tag, input int en_off);
        int f0 = 0, f1 = 0, pulses = 0;
        for (int k = 1; k <= 1100; k++) begin
            tick();
            if (k == en_off) en = 1'b0;
            if (f0 == 0 && !busy0) f0 = k;
            if (f1 == 0 && !busy1) f1 = k;
            pulses += int'(vld0) + int'(vld1);
        end
        check({tag, " d0 busy cycles"}, f0, 1024);
        check({tag, " d1 busy cycles"}, f1, 1000);
        check({tag, " no pulses"}, pulses, 0);
        check({tag, " d0 busy end"}, busy0, 0);
        check({tag, " d1 busy end"}, busy1, 0);
    endtask

    task automatic read_chk(input string tag, input logic [9:0] a,
                            input logic [31:0] e0, input logic [31:0] e1);
        access(1'b0, a, 4'h0, 32'h0);
        check({tag, " d0 vld@1"}, vld0, 1);
        check({tag, " d0 out"}, out0, e0);
        check({tag, " d1 vld@1"}, vld1, 0);
        tick();
        check({tag, " d0 vld@2"}, vld0, 0);
        check({tag, " d1 vld@2"}, vld1, 1);
        check({tag, " d1 out"}, out1, e1);
        tick();
        check({tag, " d1 vld@3"}, vld1, 0);
    endtask

    // d0 is no-change: out holds prev0, with no pulse. d1 is write-first: shows e1 at latency 2.
    task automatic write_chk(input string tag, input logic [9:0] a, input logic [3:0] be,
                             input logic [31:0] d, input logic [31:0] e1,
                             input logic [31:0] prev0);
        access(1'b1, a, be, d);
        check({tag, " d0 vld@1"}, vld0, 0);
        check({tag, " d0 out@1"}, out0, prev0);
        check({tag, " d1 vld@1"}, vld1, 0);
        tick();
        check({tag, " d0 vld@2"}, vld0, 0);
        check({tag, " d0 out@2"}, out0, prev0);
        check({tag, " d1 vld@2"}, vld1, 1);
        check({tag, " d1 out"}, out1, e1);
        tick();
        check({tag, " d1 vld@3"}, vld1, 0);
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; wren = 1'b0; address = '0; byteena = '0; data = '0;
        repeat (3) tick();
        check("rst d0 out", out0, 0);
        check("rst d0 vld", vld0, 0);
        check("rst d0 busy", busy0, 1);
        check("rst d1 out", out1, 0);
        check("rst d1 vld", vld1, 0);
        check("rst d1 busy", busy1, 1);

        // A write to 9 is held on the inputs during the sweep and must be dropped.
        en = 1'b1; wren = 1'b1; address = 10'd9; byteena = 4'hF; data = 32'hFFFF_FFFF;
        reset = 1'b0;
        init_sweep("init1", 500);

        read_chk("rd3FF", 10'h3FF, 32'h0, 32'h0);
        read_chk("rd9 dropped", 10'd9, 32'h0, 32'h0);

        write_chk("wr5 full", 10'd5, 4'hF, 32'hAABB_CCDD, 32'hAABB_CCDD, 32'h0);
        write_chk("wr5 be0101", 10'd5, 4'b0101, 32'h1122_3344, 32'hAA22_CC44, 32'h0);
        write_chk("wr5 be0000", 10'd5, 4'b0000, 32'hFFFF_FFFF, 32'hAA22_CC44, 32'h0);
        read_chk("rd5", 10'd5, 32'hAA22_CC44, 32'hAA22_CC44);

        write_chk("wr7", 10'd7, 4'hF, 32'h1234_5678, 32'h1234_5678, 32'hAA22_CC44);
        read_chk("rd7", 10'd7, 32'h1234_5678, 32'h1234_5678);

        // Back-to-back writes to 1, 2, 3
        en = 1'b1; wren = 1'b1; byteena = 4'hF;
        address = 10'd1; data = 32'h0101_A1A1; tick();
        check("bw d0 no pulse", vld0, 0);
        address = 10'd2; data = 32'h0202_B2B2; tick();
        address = 10'd3; data = 32'h0303_C3C3; tick();
        en = 1'b0; wren = 1'b0;
        tick(); tick();
        check("bw d0 out hold", out0, 32'h1234_5678);
        check("bw d1 out last", out1, 32'h0303_C3C3);
        check("bw d1 vld idle", vld1, 0);

        // Streaming reads of 1, 2, 3
        en = 1'b1; wren = 1'b0; address = 10'd1; tick();
        check("st c1 d0 vld", vld0, 1);
        check("st c1 d0 out", out0, 32'h0101_A1A1);
        check("st c1 d1 vld", vld1, 0);
        address = 10'd2; tick();
        check("st c2 d0 vld", vld0, 1);
        check("st c2 d0 out", out0, 32'h0202_B2B2);
        check("st c2 d1 vld", vld1, 1);
        check("st c2 d1 out", out1, 32'h0101_A1A1);
        address = 10'd3; tick();
        check("st c3 d0 vld", vld0, 1);
        check("st c3 d0 out", out0, 32'h0303_C3C3);
        check("st c3 d1 vld", vld1, 1);
        check("st c3 d1 out", out1, 32'h0202_B2B2);
        en = 1'b0; tick();
        check("st c4 d0 vld", vld0, 0);
        check("st c4 d0 out", out0, 32'h0303_C3C3);
        check("st c4 d1 vld", vld1, 1);
        check("st c4 d1 out", out1, 32'h0303_C3C3);
        tick();
        check("st c5 d1 vld", vld1, 0);
        check("st c5 d1 out", out1, 32'h0303_C3C3);
        check("st c5 d0 out", out0, 32'h0303_C3C3);

        // Address 1010 is in range for d0 (DEPTH 1024) but out of range for d1 (DEPTH 1000).
        access(1'b1, 10'd1010, 4'hF, 32'hDEAD_BEEF);
        check("wr1010 d0 vld", vld0, 0);
        tick(); tick();
        read_chk("rd1010", 10'd1010, 32'hDEAD_BEEF, 32'h0);
        read_chk("rd10", 10'd10, 32'h0, 32'h0);

        // Reset while d1 still holds the read in its pipeline
        access(1'b0, 10'd5, 4'h0, 32'h0);
        check("rr d0 vld", vld0, 1);
        check("rr d0 out", out0, 32'hAA22_CC44);
        check("rr d1 vld pre", vld1, 0);
        reset = 1'b1;
        #1;
        check("rr d0 out rst", out0, 0);
        check("rr d0 vld rst", vld0, 0);
        check("rr d0 busy rst", busy0, 1);
        check("rr d1 out rst", out1, 0);
        check("rr d1 vld rst", vld1, 0);
        check("rr d1 busy rst", busy1, 1);
        tick(); tick();
        reset = 1'b0;
        init_sweep("init2", 0);
        read_chk("rd5 reinit", 10'd5, 32'h0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/spram_be_init.md
SPRAM_BE_INIT -- requirements
Module: spram_be_init

Interface
REQ-001 SHALL have parameter AW, default 10, address width in bits.
REQ-002 SHALL have parameter DEPTH, default 1024, number of words; legal range 2..2**AW.
REQ-003 SHALL have parameter DW, default 32, data width in bits; SHALL be a multiple of 8.
REQ-004 SHALL have parameter OUT_REG, default 0; 0 gives 1-cycle read latency, 1 adds an output register for 2-cycle latency.
REQ-005 SHALL have parameter WRITE_FIRST, default 0; 0 = no-change on write, 1 = write-first read-back.
REQ-006 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port en, input, 1, access request, sampled each cycle.
REQ-009 SHALL have port address, input, AW, word address.
REQ-010 SHALL have port wren, input, 1, 1 = write, 0 = read; meaningful only with en=1.
REQ-011 SHALL have port byteena, input, DW/8, per-byte write enable; bit i covers data[8i+7:8i].
REQ-012 SHALL have port data, input, DW, write data.
REQ-013 SHALL have port out, output, DW, registered read data.
REQ-014 SHALL have port out_valid, output, 1, one-cycle pulse marking new data on out.
REQ-015 SHALL have port busy, output, 1, high while the init sweep is running.

Function
REQ-016 An access SHALL be accepted only when en=1 and busy=0; requests with busy=1 SHALL be dropped, with no queueing.
REQ-017 On an accepted write, bytes with byteena[i]=1 SHALL be updated; all other bytes SHALL keep their old value.
REQ-018 A write with byteena all-zero SHALL leave memory unchanged.
REQ-019 On an accepted read, the word at address SHALL appear on out with out_valid=1 exactly 1+OUT_REG cycles after acceptance.
REQ-020 With WRITE_FIRST=0, a write SHALL NOT change out and SHALL NOT pulse out_valid.
REQ-021 With WRITE_FIRST=1, a write SHALL present the merged post-write word on out with out_valid, at the same latency as a read.
REQ-022 Back-to-back accepted accesses SHALL be sustained at one per cycle; out_valid SHALL pulse once per qualifying access, in order.
REQ-023 When no new data arrives, out SHALL hold its last value and out_valid SHALL be 0.
REQ-024 For address >= DEPTH, writes SHALL be dropped, and reads SHALL return 0 with normal out_valid timing.
REQ-025 The init FSM SHALL have states INIT and READY.
REQ-026 In INIT, a counter SHALL write all-zero to addresses 0..DEPTH-1, one word per cycle, with busy=1.
REQ-027 INIT SHALL move to READY in the cycle after address DEPTH-1 is written; busy SHALL be 0 in READY.
REQ-028 READY SHALL be terminal until the next reset.
REQ-029 After reset release, busy SHALL stay high for exactly DEPTH cycles.

Reset
REQ-030 While reset=1, the following SHALL hold asynchronously: out=0, out_valid=0, busy=1, state=INIT, init counter=0, and the read pipeline flushed.
REQ-031 Reset asserted mid-operation SHALL discard any in-flight read, so no out_valid occurs for it after release.
REQ-032 Reset asserted mid-operation SHALL restart the init sweep from address 0.
REQ-033 Memory contents SHALL NOT be relied upon between reset assertion and busy falling.

Verification
REQ-034 Init scenario: release reset with DEPTH=1024 -> busy=1 for exactly 1024 cycles, then 0; a read of 0x3FF then returns 0x00000000.
REQ-035 Byte-enable scenario: write 0xAABBCCDD to addr 5 with byteena=1111, then 0x11223344 with byteena=0101 -> a read of 5 returns 0xAA22CC44, with out_valid at cycle+1 (OUT_REG=0) or cycle+2 (OUT_REG=1).
REQ-036 Streaming scenario: after init, reads of addrs 1,2,3 on consecutive cycles -> three consecutive out_valid pulses carrying the data of 1,2,3 in order; out holds the addr-3 data afterwards.
REQ-037 Write-mode scenario: write 0x12345678 to addr 7 -> WRITE_FIRST=1 shows 0x12345678 with out_valid; WRITE_FIRST=0 leaves out unchanged with no pulse.
REQ-038 Reset-during-read scenario: issue a read, then assert reset before the output cycle -> no out_valid for that read; out=0; busy=1; init restarts at 0 and lasts DEPTH cycles.
REQ-039 Busy and range scenario: en=1 with wren=1 during busy -> write dropped and location reads 0 after init; with DEPTH=1000 and AW=10, a read of 1010 returns 0.
